uart_rx_frame: RTL

//  UART receiver for the 8N1 link; the serial-in end of the UART project, mirroring the

---
 rtl/uart_rx_frame.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_frame.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_rx_frame                                              |
// | Description : 8N1 UART receiver. Synchronises the serial line, finds the |
// |               start bit, samples start, data and stop bits at mid-bit,   |
// |               and presents each byte on a valid/ready holding register   |
// |               with framing-error and overrun pulses.                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module uart_rx_frame #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8
) (
  input  logic                 SystemClock,
  input  logic                 ResetCounter,
  input  logic                 RxSerial,
  output logic [DATA_BITS-1:0] RxData,
  output logic                 RxValid,
  input  logic                 RxReady,
  output logic                 FrameError,
  output logic                 Overrun,
  output logic                 Busy
);

  localparam int c_CW = $clog2(CLKS_PER_BIT);
  localparam int c_BW = $clog2(DATA_BITS + 1);

  // Half-bit terminal count lands the start-bit sample near its centre; every
  // later sample is one full bit period after the previous one.
  localparam logic [c_CW-1:0] c_HALF_LAST = c_CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_CW-1:0] c_BIT_LAST  = c_CW'(CLKS_PER_BIT - 1);
  localparam logic [c_BW-1:0] c_DATA_LAST = c_BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_sync1, r_rx_s;
  logic [c_CW-1:0]       r_cnt, w_cnt_nxt;
  logic [c_BW-1:0]       r_bitcnt, w_bitcnt_nxt;
  logic [DATA_BITS-1:0]  r_shreg, w_shreg_nxt;
  logic                  r_deliver, w_deliver_nxt;
  logic                  r_ferr, w_ferr_nxt;

  // Two-flop synchroniser for the asynchronous line; idle level is high.
  always_ff @(posedge SystemClock or negedge ResetCounter) begin
    if (!ResetCounter) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= RxSerial;
      r_rx_s  <= r_sync1;
    end
  end

  // Receiver state, counters, shift register and the one-cycle event strobes.
  always_ff @(posedge SystemClock or negedge ResetCounter) begin
    if (!ResetCounter) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bitcnt  <= '0;
      r_shreg   <= '0;
      r_deliver <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bitcnt  <= w_bitcnt_nxt;
      r_shreg   <= w_shreg_nxt;
      r_deliver <= w_deliver_nxt;
      r_ferr    <= w_ferr_nxt;
    end
  end

  // Next-state logic: bit timing, sampling decisions and frame outcome.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bitcnt_nxt  = r_bitcnt;
    w_shreg_nxt   = r_shreg;
    w_deliver_nxt = 1'b0;
    w_ferr_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_rx_s) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = '0;
        end
      end
      S_START: begin
        if (r_cnt == c_HALF_LAST) begin
          w_cnt_nxt = '0;
          if (!r_rx_s) begin
            w_state_nxt  = S_DATA;
            w_bitcnt_nxt = '0;
          end else begin
            // Line went back high before mid start bit: treat as noise.
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (r_cnt == c_BIT_LAST) begin
          w_cnt_nxt    = '0;
          w_shreg_nxt  = {r_rx_s, r_shreg[DATA_BITS-1:1]};
          w_bitcnt_nxt = r_bitcnt + 1'b1;
          if (r_bitcnt == c_DATA_LAST) begin
            w_state_nxt = S_STOP;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (r_cnt == c_BIT_LAST) begin
          w_cnt_nxt = '0;
          if (r_rx_s) begin
            w_deliver_nxt = 1'b1;
            w_state_nxt   = S_IDLE;
          end else begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_BREAK: begin
        // A line held low must return high before another frame can start.
        if (r_rx_s) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Holding register: load on delivery, drop with overrun if still occupied.
  always_ff @(posedge SystemClock or negedge ResetCounter) begin
    if (!ResetCounter) begin
      RxData  <= '0;
      RxValid <= 1'b0;
      Overrun <= 1'b0;
    end else begin
      Overrun <= 1'b0;
      if (r_deliver) begin
        if (!RxValid || RxReady) begin
          RxData  <= r_shreg;
          RxValid <= 1'b1;
        end else begin
          Overrun <= 1'b1;
        end
      end else if (RxValid && RxReady) begin
        RxValid <= 1'b0;
      end
    end
  end

  assign FrameError = r_ferr;
  assign Busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire
